huffman_ac_rle: RTL and testbench

Parametrised AC run-length symbol generator for the JPEG encoder. It accepts one quantised, zig-zag-ordered coefficient block per handshake and scans the AC coefficients (indices 1..BLOCK_N-1) one index per cycle. For each block it emits a stream of (run, size, amplitude) symbols, inserting ZRL and EOB where required, over a valid/ready interface. It sits between the quantiser/zig-zag stage and the Huffman code-table lookup. It replaces the fixed 64×10-bit single-pass AC encoder with backpressure support, selectable width and depth, and luma/chroma tagging.

---
 rtl/jpeg_enc_pkg.sv | 19 +
 rtl/ac_mag_cat.sv | 32 +++
 rtl/huffman_ac_rle.sv | 248 ++++++++++++++++++++++++
 tb/tb_huffman_ac_rle.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_enc_pkg.sv
// Shared JPEG encoder definitions: symbol field widths, special AC symbols
// and the AC run-length FSM state encoding.
package jpeg_enc_pkg;

  localparam int RUN_W  = 4;
  localparam int SIZE_W = 4;

  localparam logic [7:0] SYM_EOB = 8'h00;
  localparam logic [7:0] SYM_ZRL = 8'hF0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ZRL,
    ST_EMIT,
    ST_EOB
  } ac_state_e;

endpackage

// File: rtl/ac_mag_cat.sv
// Magnitude category: maps a two's complement value to its JPEG {size, amp}.
// Negative values use the one's complement form (v-1) truncated to size bits.
module ac_mag_cat
  import jpeg_enc_pkg::*;
#(
  parameter int COEF_W = 10
) (
  input  logic [COEF_W-1:0] value,
  output logic [SIZE_W-1:0] size,
  output logic [COEF_W-1:0] amp
);

  logic [COEF_W-1:0] mag;
  logic [COEF_W-1:0] mask;
  logic [COEF_W-1:0] vm1;

  always_comb begin
    // The most-negative value negates to 2^(COEF_W-1), which still fits unsigned.
    mag  = value[COEF_W-1] ? (~value + COEF_W'(1)) : value;
    size = '0;
    for (int b = 0; b < COEF_W; b++) begin
      if (mag[b]) size = SIZE_W'(b + 1);
    end
    mask = '0;
    for (int b = 0; b < COEF_W; b++) begin
      if (SIZE_W'(b) < size) mask[b] = 1'b1;
    end
    vm1 = value - COEF_W'(1);
    amp = (value[COEF_W-1] ? vm1 : value) & mask;
  end

endmodule

// File: rtl/huffman_ac_rle.sv
// AC run-length symbol generator: scans coefficients 1..BLOCK_N-1 of one block
// and emits (run, size, amp) symbols with ZRL/EOB insertion over valid/ready.
module huffman_ac_rle
  import jpeg_enc_pkg::*;
#(
  parameter int COEF_W  = 10,
  parameter int BLOCK_N = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BLOCK_N*COEF_W-1:0] in_block,
  input  logic                      in_luma,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [RUN_W-1:0]          out_run,
  output logic [SIZE_W-1:0]         out_size,
  output logic [COEF_W-1:0]         out_amp,
  output logic                      out_zrl,
  output logic                      out_eob,
  output logic                      out_last,
  output logic [7:0]                out_pos,
  output logic                      out_luma,
  output logic                      busy
);

  localparam int IDX_W = $clog2(BLOCK_N);

  ac_state_e                 state_q, state_d;
  logic [BLOCK_N*COEF_W-1:0] block_q, block_d;
  logic                      luma_q, luma_d;
  logic [IDX_W-1:0]          last_nz_q, last_nz_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [IDX_W-1:0]          run_q, run_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic [RUN_W-1:0]          out_run_q, out_run_d;
  logic [SIZE_W-1:0]         out_size_q, out_size_d;
  logic [COEF_W-1:0]         out_amp_q, out_amp_d;
  logic                      out_zrl_q, out_zrl_d;
  logic                      out_eob_q, out_eob_d;
  logic                      out_last_q, out_last_d;
  logic [7:0]                out_pos_q, out_pos_d;
  logic                      out_luma_q, out_luma_d;
  logic                      busy_q, busy_d;

  logic [IDX_W-1:0]  last_nz_in;
  logic [IDX_W-1:0]  run_left;
  logic [IDX_W-1:0]  emit_run;
  logic [COEF_W-1:0] coef_cur;
  logic [SIZE_W-1:0] cur_size;
  logic [COEF_W-1:0] cur_amp;
  logic              cur_last;
  logic              ld_emit, ld_zrl, ld_eob, ld_clr;

  assign coef_cur = block_q[int'(idx_q)*COEF_W +: COEF_W];
  assign cur_last = (idx_q == IDX_W'(BLOCK_N-1));
  assign run_left = run_q - IDX_W'(16);

  ac_mag_cat #(.COEF_W(COEF_W)) u_mag_cat (
    .value (coef_cur),
    .size  (cur_size),
    .amp   (cur_amp)
  );

  always_comb begin
    last_nz_in = '0;
    for (int k = 1; k < BLOCK_N; k++) begin
      if (in_block[k*COEF_W +: COEF_W] != '0) last_nz_in = IDX_W'(k);
    end
  end

  always_comb begin
    state_d     = state_q;
    block_d     = block_q;
    luma_d      = luma_q;
    last_nz_d   = last_nz_q;
    idx_d       = idx_q;
    run_d       = run_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_run_d   = out_run_q;
    out_size_d  = out_size_q;
    out_amp_d   = out_amp_q;
    out_zrl_d   = out_zrl_q;
    out_eob_d   = out_eob_q;
    out_last_d  = out_last_q;
    out_pos_d   = out_pos_q;
    out_luma_d  = out_luma_q;
    emit_run    = run_q;
    ld_emit     = 1'b0;
    ld_zrl      = 1'b0;
    ld_eob      = 1'b0;
    ld_clr      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          block_d    = in_block;
          luma_d     = in_luma;
          last_nz_d  = last_nz_in;
          idx_d      = IDX_W'(1);
          run_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (idx_q > last_nz_q) begin
          state_d = ST_EOB;
          ld_eob  = 1'b1;
        end else if (coef_cur == '0) begin
          idx_d = idx_q + IDX_W'(1);
          run_d = run_q + IDX_W'(1);
        end else if (int'(run_q) >= 16) begin
          state_d = ST_ZRL;
          ld_zrl  = 1'b1;
        end else begin
          state_d = ST_EMIT;
          ld_emit = 1'b1;
        end
      end
      ST_ZRL: begin
        if (out_ready) begin
          run_d = run_left;
          if (int'(run_left) >= 16) begin
            ld_zrl = 1'b1;
          end else begin
            state_d  = ST_EMIT;
            emit_run = run_left;
            ld_emit  = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          ld_clr = 1'b1;
          if (cur_last) begin
            state_d    = ST_IDLE;
            in_ready_d = 1'b1;
          end else begin
            run_d   = '0;
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_SCAN;
          end
        end
      end
      ST_EOB: begin
        if (out_ready) begin
          ld_clr     = 1'b1;
          state_d    = ST_IDLE;
          in_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ld_clr) begin
      out_valid_d = 1'b0;
      out_run_d   = '0;
      out_size_d  = '0;
      out_amp_d   = '0;
      out_zrl_d   = 1'b0;
      out_eob_d   = 1'b0;
      out_last_d  = 1'b0;
      out_pos_d   = '0;
      out_luma_d  = 1'b0;
    end
    if (ld_zrl || ld_emit || ld_eob) begin
      out_valid_d = 1'b1;
      out_pos_d   = 8'(idx_q);
      out_luma_d  = luma_q;
      out_zrl_d   = ld_zrl;
      out_eob_d   = ld_eob;
      out_last_d  = ld_eob || (ld_emit && cur_last);
      out_amp_d   = ld_emit ? cur_amp : '0;
    end
    if (ld_zrl) begin
      out_run_d  = SYM_ZRL[7:4];
      out_size_d = SYM_ZRL[3:0];
    end
    if (ld_eob) begin
      out_run_d  = SYM_EOB[7:4];
      out_size_d = SYM_EOB[3:0];
    end
    if (ld_emit) begin
      out_run_d  = RUN_W'(emit_run);
      out_size_d = cur_size;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      block_q     <= '0;
      luma_q      <= 1'b0;
      last_nz_q   <= '0;
      idx_q       <= '0;
      run_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_run_q   <= '0;
      out_size_q  <= '0;
      out_amp_q   <= '0;
      out_zrl_q   <= 1'b0;
      out_eob_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_pos_q   <= '0;
      out_luma_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      block_q     <= block_d;
      luma_q      <= luma_d;
      last_nz_q   <= last_nz_d;
      idx_q       <= idx_d;
      run_q       <= run_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_run_q   <= out_run_d;
      out_size_q  <= out_size_d;
      out_amp_q   <= out_amp_d;
      out_zrl_q   <= out_zrl_d;
      out_eob_q   <= out_eob_d;
      out_last_q  <= out_last_d;
      out_pos_q   <= out_pos_d;
      out_luma_q  <= out_luma_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_run   = out_run_q;
  assign out_size  = out_size_q;
  assign out_amp   = out_amp_q;
  assign out_zrl   = out_zrl_q;
  assign out_eob   = out_eob_q;
  assign out_last  = out_last_q;
  assign out_pos   = out_pos_q;
  assign out_luma  = out_luma_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_huffman_ac_rle.sv
// Bench for huffman_ac_rle: directed and random blocks under backpressure,
// compared against a symbol-list model built from the JPEG AC coding rules.
module tb_huffman_ac_rle;

  localparam int CW  = 10;
  localparam int BN  = 64;
  localparam int CW2 = 11;
  localparam int BN2 = 16;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0, in_luma = 1'b0, out_ready = 1'b0;
  logic [BN*CW-1:0] in_block = '0;
  logic            in_ready, out_valid, out_zrl, out_eob, out_last, out_luma, busy;
  logic [3:0]      out_run, out_size;
  logic [CW-1:0]   out_amp;
  logic [7:0]      out_pos;

  logic              in_valid2 = 1'b0, in_luma2 = 1'b0, out_ready2 = 1'b0;
  logic [BN2*CW2-1:0] in_block2 = '0;
  logic              in_ready2, out_valid2, out_zrl2, out_eob2, out_last2, out_luma2, busy2;
  logic [3:0]        out_run2, out_size2;
  logic [CW2-1:0]    out_amp2;
  logic [7:0]        out_pos2;

  typedef struct {
    int run; int size; int amp; bit zrl; bit eob; bit last; int pos;
  } sym_t;

  sym_t exp_q[$];
  int   coef[BN];
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  huffman_ac_rle #(.COEF_W(CW), .BLOCK_N(BN)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_luma(in_luma), .out_valid(out_valid), .out_ready(out_ready),
    .out_run(out_run), .out_size(out_size), .out_amp(out_amp), .out_zrl(out_zrl),
    .out_eob(out_eob), .out_last(out_last), .out_pos(out_pos), .out_luma(out_luma),
    .busy(busy)
  );

  huffman_ac_rle #(.COEF_W(CW2), .BLOCK_N(BN2)) dut11 (
    .clock(clock), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_block(in_block2), .in_luma(in_luma2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_run(out_run2), .out_size(out_size2), .out_amp(out_amp2), .out_zrl(out_zrl2),
    .out_eob(out_eob2), .out_last(out_last2), .out_pos(out_pos2), .out_luma(out_luma2),
    .busy(busy2)
  );

  function automatic int size_of(input int v);
    int a = (v < 0) ? -v : v;
    int s = 0;
    while (a != 0) begin a = a >> 1; s++; end
    return s;
  endfunction

  function automatic void push_sym(input int run, input int size, input int amp,
                                   input bit zrl, input bit eob, input bit last, input int pos);
    sym_t s;
    s.run = run; s.size = size; s.amp = amp; s.zrl = zrl; s.eob = eob; s.last = last; s.pos = pos;
    exp_q.push_back(s);
  endfunction

  // Expected symbol list straight from the JPEG AC rules.
  function automatic void build_model();
    int last_nz = 0;
    int run = 0;
    int s;
    exp_q.delete();
    for (int k = 1; k < BN; k++) if (coef[k] != 0) last_nz = k;
    for (int k = 1; k <= last_nz; k++) begin
      if (coef[k] == 0) run++;
      else begin
        while (run >= 16) begin push_sym(15, 0, 0, 1, 0, 0, k); run -= 16; end
        s = size_of(coef[k]);
        push_sym(run, s, (coef[k] > 0) ? coef[k] : coef[k] + (1 << s) - 1, 0, 0, k == BN-1, k);
        run = 0;
      end
    end
    if (last_nz != BN-1) push_sym(0, 0, 0, 0, 1, 1, last_nz + 1);
  endfunction

  task automatic clear_coef();
    for (int k = 0; k < BN; k++) coef[k] = 0;
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic run_block(input bit luma, input int stall_pct, output int first_cyc, output int acc_wait);
    int n, cyc;
    bit done, stalled;
    sym_t e;
    logic [29:0] got, want;
    build_model();
    for (int k = 0; k < BN; k++) in_block[k*CW +: CW] = coef[k][CW-1:0];
    in_luma = luma;
    in_valid = 1'b1;
    first_cyc = -1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin step(); n++; end
    acc_wait = n;
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    step();
    in_valid = 1'b0;
    total++;
    if ({in_ready, busy} !== 2'b01) begin
      bad++;
      $display("FAIL accept_state: in_ready,busy=%b required 01", {in_ready, busy});
    end
    cyc = 1; done = 0; stalled = 0;
    while (!done && cyc < 3000) begin
      out_ready = ($urandom_range(99) >= stall_pct);
      if (out_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_symbol: run=%0d size=%0d pos=%0d required none", out_run, out_size, out_pos);
          done = 1;
        end else begin
          e = exp_q[0];
          want = {4'(e.run), 4'(e.size), 10'(e.amp), e.zrl, e.eob, e.last, 8'(e.pos), luma};
          got  = {out_run, out_size, out_amp, out_zrl, out_eob, out_last, out_pos, out_luma};
          if (got !== want) begin
            bad++;
            $display("FAIL symbol: got run=%0d size=%0d amp=%h zrl=%b eob=%b last=%b pos=%0d luma=%b required run=%0d size=%0d amp=%h zrl=%b eob=%b last=%b pos=%0d luma=%b",
                     out_run, out_size, out_amp, out_zrl, out_eob, out_last, out_pos, out_luma,
                     e.run, e.size, e.amp, e.zrl, e.eob, e.last, e.pos, luma);
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (e.last) done = 1;
          end
        end
      end else if (stalled) begin
        total++; bad++;
        $display("FAIL valid_dropped: out_valid=%b required 1", out_valid);
      end
      stalled = (out_valid === 1'b1) && !out_ready;
      step();
      cyc++;
    end
    out_ready = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL stream_timeout: %0d symbols outstanding required 0", exp_q.size());
    end else if ({in_ready, busy, out_valid} !== 3'b100) begin
      bad++;
      $display("FAIL ready_return: in_ready,busy,out_valid=%b required 100", {in_ready, busy, out_valid});
    end
  endtask

  task automatic gen_random_block();
    int lim, dens, v;
    clear_coef();
    coef[0] = int'($urandom_range(1023)) - 512;
    lim  = $urandom_range(BN-1);
    dens = $urandom_range(60, 3);
    for (int k = 1; k <= lim; k++) begin
      if ($urandom_range(99) < dens) begin
        case ($urandom_range(3))
          0: v = int'($urandom_range(7, 1));
          1: v = int'($urandom_range(1023)) - 512;
          2: v = -512;
          default: v = -int'($urandom_range(7, 1));
        endcase
        coef[k] = (v == 0) ? 1 : v;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    total++;
    if ({in_ready, out_valid, out_run, out_size, out_amp, out_zrl, out_eob, out_last,
         out_pos, out_luma, busy, in_ready2, out_valid2, busy2} !== '0) begin
      bad++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b busy=%b pos=%0d required all 0",
               in_ready, out_valid, busy, out_pos);
    end
    reset = 1'b0;
    step();
    total++;
    if ({in_ready, busy, out_valid, in_ready2} !== 4'b1001) begin
      bad++;
      $display("FAIL reset_release: in_ready,busy,out_valid,in_ready2=%b required 1001",
               {in_ready, busy, out_valid, in_ready2});
    end
  endtask

  task automatic test_all_zero();
    int f, w;
    clear_coef();
    coef[0] = 55;
    run_block(1'b1, 0, f, w);
    total++;
    if (f != 2) begin
      bad++;
      $display("FAIL eob_latency: first symbol at cycle %0d required 2", f);
    end
  endtask

  task automatic test_directed();
    int f, w;
    clear_coef(); coef[1] = 5; coef[2] = -3;  run_block(1'b0, 0, f, w);
    clear_coef(); coef[20] = 1;               run_block(1'b1, 0, f, w);
    clear_coef(); coef[63] = -1;              run_block(1'b0, 30, f, w);
    clear_coef(); coef[1] = -512;             run_block(1'b1, 0, f, w);
    clear_coef(); coef[62] = 511; coef[63] = 3; run_block(1'b0, 50, f, w);
  endtask

  task automatic test_most_negative_w11();
    int n;
    in_block2 = '0;
    in_block2[1*CW2 +: CW2] = 11'h400;
    in_luma2 = 1'b1;
    in_valid2 = 1'b1;
    out_ready2 = 1'b1;
    n = 0;
    while (in_ready2 !== 1'b1 && n < 20) begin step(); n++; end
    step();
    in_valid2 = 1'b0;
    n = 0;
    while (out_valid2 !== 1'b1 && n < 50) begin step(); n++; end
    total++;
    if ({out_valid2, out_run2, out_size2, out_amp2, out_zrl2, out_eob2, out_last2, out_pos2, out_luma2}
        !== {1'b1, 4'd0, 4'd11, 11'h3FF, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1}) begin
      bad++;
      $display("FAIL w11_most_negative: valid=%b run=%0d size=%0d amp=%h pos=%0d required 1 0 11 3ff 1",
               out_valid2, out_run2, out_size2, out_amp2, out_pos2);
    end
    step();
    n = 0;
    while (out_valid2 !== 1'b1 && n < 50) begin step(); n++; end
    total++;
    if ({out_valid2, out_run2, out_size2, out_amp2, out_zrl2, out_eob2, out_last2, out_pos2}
        !== {1'b1, 4'd0, 4'd0, 11'h0, 1'b0, 1'b1, 1'b1, 8'd2}) begin
      bad++;
      $display("FAIL w11_eob: valid=%b eob=%b last=%b pos=%0d required 1 1 1 2",
               out_valid2, out_eob2, out_last2, out_pos2);
    end
    step();
    out_ready2 = 1'b0;
    total++;
    if ({in_ready2, out_valid2, busy2} !== 3'b100) begin
      bad++;
      $display("FAIL w11_done: in_ready,out_valid,busy=%b required 100", {in_ready2, out_valid2, busy2});
    end
  endtask

  task automatic test_back_to_back();
    int f, w1, w2;
    clear_coef(); coef[3] = 7; coef[17] = -100;
    run_block(1'b1, 20, f, w1);
    clear_coef(); coef[1] = 1; coef[63] = 2;
    run_block(1'b0, 20, f, w2);
    total++;
    if (w2 != 0) begin
      bad++;
      $display("FAIL back_to_back: waited %0d cycles for in_ready required 0", w2);
    end
  endtask

  task automatic test_random_backpressure();
    int f, w;
    for (int b = 0; b < 1000; b++) begin
      gen_random_block();
      run_block(1'($urandom_range(1)), 25, f, w);
    end
  endtask

  task automatic test_reset_mid_zrl();
    int n, f, w;
    clear_coef();
    coef[40] = 1;
    for (int k = 0; k < BN; k++) in_block[k*CW +: CW] = coef[k][CW-1:0];
    in_valid = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin step(); n++; end
    step();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin step(); n++; end
    total++;
    if ({out_valid, out_zrl} !== 2'b11) begin
      bad++;
      $display("FAIL zrl_reached: out_valid,out_zrl=%b required 11", {out_valid, out_zrl});
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({out_valid, out_zrl, busy, in_ready, out_pos, out_run} !== '0) begin
      bad++;
      $display("FAIL reset_mid_zrl: out_valid=%b zrl=%b busy=%b in_ready=%b required 0",
               out_valid, out_zrl, busy, in_ready);
    end
    step();
    reset = 1'b0;
    run_block(1'b1, 25, f, w);
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_directed();
    test_most_negative_w11();
    test_back_to_back();
    test_reset_mid_zrl();
    test_random_backpressure();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
